// File: rtl/page_feeder_pkg.sv
// Shared definitions for the page feeder: default geometry and FSM state encoding.
package page_feeder_pkg;

    localparam int PF_LEN_DATA  = 25;
    localparam int PF_SIZE_PAGE = 64;

    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_HALT   = 3'd4
    } pf_state_e;

endpackage

// File: rtl/page_feeder_buf.sv
// page_buf: one page of cell storage, synchronous write port and combinational read port.
module page_buf
    import page_feeder_pkg::*;
#(
    parameter int LEN_DATA  = PF_LEN_DATA,
    parameter int SIZE_PAGE = PF_SIZE_PAGE,
    parameter int ADDR_W    = $clog2(SIZE_PAGE)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [LEN_DATA-1:0] wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [LEN_DATA-1:0] rdata_o
);

    logic [LEN_DATA-1:0] mem_q [SIZE_PAGE];

    // Cell write; contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/page_feeder.sv
// Page feeder: collects SIZE_PAGE cell words, then streams them to the shifter one per cycle.
// Define PAGE_FEEDER_PINGPONG_EN for two banks so filling overlaps streaming.
module page_feeder
    import page_feeder_pkg::*;
#(
    parameter int LEN_DATA  = PF_LEN_DATA,
    parameter int SIZE_PAGE = PF_SIZE_PAGE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [LEN_DATA-1:0] in_data,
    output logic                in_ready,
    output logic                sh_start,
    output logic [LEN_DATA-1:0] sh_data,
    input  logic                sh_one_done,
    input  logic                sh_done,
    output logic [15:0]         page_count,
    output logic                busy
);

    localparam int ADDR_W = $clog2(SIZE_PAGE);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(SIZE_PAGE - 1);
    localparam logic [ADDR_W-1:0] ZERO_CELL = {ADDR_W{1'b0}};
`ifdef PAGE_FEEDER_PINGPONG_EN
    localparam logic PINGPONG = 1'b1;
`else
    localparam logic PINGPONG = 1'b0;
`endif

    pf_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          full_q, full_d;
    logic                od_q, od_d;
    logic [15:0]         page_cnt_q, page_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                sh_start_q, sh_start_d;
    logic [LEN_DATA-1:0] sh_data_q, sh_data_d;
    logic                busy_q, busy_d;
    logic                hs_s;
    logic [LEN_DATA-1:0] rd_data_s;
    logic [LEN_DATA-1:0] rd_data0_s;

    assign hs_s = in_valid & in_ready_q;

    // Fill-side pointer/bank bookkeeping and the stream-side FSM.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        full_d     = full_q;
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_bank_d  = rd_bank_q;
        od_d       = od_q;
        page_cnt_d = page_cnt_q;

        if (hs_s) begin
            if (wr_ptr_q == LAST_CELL) begin
                wr_ptr_d          = ZERO_CELL;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = PINGPONG & ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (sh_done) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (full_d[rd_bank_q]) begin
                        state_d  = S_START;
                        rd_ptr_d = ZERO_CELL;
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_START: begin
                    state_d  = S_STREAM;
                    rd_ptr_d = ADDR_W'(1);
                    od_d     = od_q | sh_one_done;
                end
                S_STREAM: begin
                    od_d = od_q | sh_one_done;
                    if (rd_ptr_q == LAST_CELL) begin
                        state_d = S_WAIT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (sh_one_done | od_q) begin
                        od_d              = 1'b0;
                        page_cnt_d        = page_cnt_q + 16'd1;
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = PINGPONG & ~rd_bank_q;
                        // With two banks, a page that is already complete starts at once.
                        if (full_d[rd_bank_d]) begin
                            state_d  = S_START;
                            rd_ptr_d = ZERO_CELL;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FILL;
                end
            endcase
        end
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        in_ready_d = (state_d != S_HALT) & ~full_d[wr_bank_d];
        sh_start_d = (state_d == S_START);
        busy_d     = ~((state_d == S_FILL) & (wr_ptr_d == ZERO_CELL) & (full_d == 2'b00));
        if ((state_d == S_START) || (state_d == S_STREAM)) begin
            sh_data_d = rd_data_s;
        end else begin
            sh_data_d = sh_data_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= ZERO_CELL;
            rd_ptr_q   <= ZERO_CELL;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            od_q       <= 1'b0;
            page_cnt_q <= 16'd0;
            in_ready_q <= 1'b0;
            sh_start_q <= 1'b0;
            sh_data_q  <= {LEN_DATA{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            od_q       <= od_d;
            page_cnt_q <= page_cnt_d;
            in_ready_q <= in_ready_d;
            sh_start_q <= sh_start_d;
            sh_data_q  <= sh_data_d;
            busy_q     <= busy_d;
        end
    end

    page_buf #(
        .LEN_DATA  (LEN_DATA),
        .SIZE_PAGE (SIZE_PAGE),
        .ADDR_W    (ADDR_W)
    ) u_bank0 (
        .clk_i   (clk),
        .we_i    (hs_s & ~wr_bank_q),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (rd_data0_s)
    );

`ifdef PAGE_FEEDER_PINGPONG_EN
    logic [LEN_DATA-1:0] rd_data1_s;

    page_buf #(
        .LEN_DATA  (LEN_DATA),
        .SIZE_PAGE (SIZE_PAGE),
        .ADDR_W    (ADDR_W)
    ) u_bank1 (
        .clk_i   (clk),
        .we_i    (hs_s & wr_bank_q),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (rd_data1_s)
    );

    assign rd_data_s = rd_bank_d ? rd_data1_s : rd_data0_s;
`else
    assign rd_data_s = rd_data0_s;
`endif

    assign in_ready   = in_ready_q;
    assign sh_start   = sh_start_q;
    assign sh_data    = sh_data_q;
    assign page_count = page_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_page_feeder.sv
// Directed self-checking bench for page_feeder (single-bank sequence by default,
// overlapped three-page sequence when PAGE_FEEDER_PINGPONG_EN is defined).
module tb_page_feeder;

    localparam int LEN_DATA  = 25;
    localparam int SIZE_PAGE = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [LEN_DATA-1:0] in_data;
    logic                in_ready;
    logic                sh_start;
    logic [LEN_DATA-1:0] sh_data;
    logic                sh_one_done;
    logic                sh_done;
    logic [15:0]         page_count;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef PAGE_FEEDER_PINGPONG_EN
    int   fed     = 0;
    int   starts  = 0;
    int   run     = 0;
    int   max_run = 0;
    int   cyc     = 0;
    logic drove;
`endif

    always #5 clk = ~clk;

    page_feeder #(
        .LEN_DATA  (LEN_DATA),
        .SIZE_PAGE (SIZE_PAGE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sh_start    (sh_start),
        .sh_data     (sh_data),
        .sh_one_done (sh_one_done),
        .sh_done     (sh_done),
        .page_count  (page_count),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one full page base..base+63 with in_valid held high.
    task automatic feed_page(input int base);
        for (int i = 0; i < SIZE_PAGE; i++) begin
            in_valid = 1'b1;
            in_data  = LEN_DATA'(base + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Called in the START cycle; walks the stream to the last cell.
    task automatic check_stream(input int base, input int od_at, input logic junk);
        check_eq("start_pulse", {31'd0, sh_start}, 32'd1);
        check_eq("start_data", {7'd0, sh_data}, base);
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k < SIZE_PAGE; k++) begin
            sh_one_done = (k == od_at);
            in_valid    = junk;
            in_data     = LEN_DATA'(9999);
            tick();
            check_eq("stream_data", {7'd0, sh_data}, base + k);
            check_eq("stream_start_low", {31'd0, sh_start}, 32'd0);
            if (k == 32) begin
                check_eq("stream_ready_low", {31'd0, in_ready}, 32'd0);
            end
        end
        sh_one_done = 1'b0;
        in_valid    = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        sh_one_done = 1'b0;
        sh_done     = 1'b0;
        tick();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_sh_start", {31'd0, sh_start}, 32'd0);
        check_eq("rst_sh_data", {7'd0, sh_data}, 32'd0);
        check_eq("rst_page_count", {16'd0, page_count}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

`ifndef PAGE_FEEDER_PINGPONG_EN
        // Page 1: words 0..63, then one_done five cycles after the last cell.
        feed_page(0);
        check_eq("p1_ready_low", {31'd0, in_ready}, 32'd0);
        check_stream(0, -1, 1'b0);
        for (int w = 0; w < 5; w++) begin
            tick();
            check_eq("wait_hold_data", {7'd0, sh_data}, 32'd63);
            check_eq("wait_busy", {31'd0, busy}, 32'd1);
        end
        sh_one_done = 1'b1;
        tick();
        sh_one_done = 1'b0;
        check_eq("p1_page_count", {16'd0, page_count}, 32'd1);
        check_eq("p1_ready_back", {31'd0, in_ready}, 32'd1);
        check_eq("p1_busy_idle", {31'd0, busy}, 32'd0);

        // Page 2: in_valid toggling, junk ignored while not ready, early one_done.
        for (int c = 0; c < SIZE_PAGE; c++) begin
            if (c > 0) begin
                in_valid = 1'b0;
                in_data  = LEN_DATA'(5555);
                tick();
                check_eq("toggle_ready", {31'd0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_data  = LEN_DATA'(200 + c);
            tick();
        end
        in_valid = 1'b0;
        check_stream(200, 10, 1'b1);
        tick();
        check_eq("latched_wait_data", {7'd0, sh_data}, 32'd263);
        check_eq("latched_wait_count", {16'd0, page_count}, 32'd1);
        tick();
        check_eq("latched_exit_count", {16'd0, page_count}, 32'd2);
        check_eq("latched_exit_ready", {31'd0, in_ready}, 32'd1);
        check_eq("no_stray_writes", {31'd0, busy}, 32'd0);

        // Partial page discarded by reset, then a clean page 100..163.
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = LEN_DATA'(50 + i);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check_eq("midrst_count", {16'd0, page_count}, 32'd0);
        check_eq("midrst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("midrst_ready_rise", {31'd0, in_ready}, 32'd1);
        feed_page(100);
        check_stream(100, -1, 1'b0);

        // sh_done and sh_one_done together in WAIT: HALT wins.
        tick();
        sh_done     = 1'b1;
        sh_one_done = 1'b1;
        tick();
        sh_done     = 1'b0;
        sh_one_done = 1'b0;
        check_eq("halt_count", {16'd0, page_count}, 32'd0);
        check_eq("halt_ready", {31'd0, in_ready}, 32'd0);
        check_eq("halt_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
            check_eq("halt_ready_stays", {31'd0, in_ready}, 32'd0);
            check_eq("halt_no_start", {31'd0, sh_start}, 32'd0);
        end
        in_valid = 1'b0;
`else
        // Three pages back to back with one_done returned immediately.
        while (((fed < 3 * SIZE_PAGE) || (starts < 3)) && (cyc < 2000)) begin
            in_valid    = (fed < 3 * SIZE_PAGE);
            in_data     = LEN_DATA'(fed);
            sh_one_done = 1'b1;
            drove       = in_valid & in_ready;
            tick();
            cyc++;
            if (drove) begin
                fed++;
            end
            if (sh_start) begin
                check_eq("pp_start_data", {7'd0, sh_data}, starts * SIZE_PAGE);
                starts++;
            end
            if (fed < 3 * SIZE_PAGE) begin
                if (!in_ready) begin
                    run++;
                end else begin
                    run = 0;
                end
                if (run > max_run) begin
                    max_run = run;
                end
            end
        end
        in_valid    = 1'b0;
        sh_one_done = 1'b0;
        check_eq("pp_fed", fed, 3 * SIZE_PAGE);
        check_eq("pp_starts", starts, 32'd3);
        check_eq("pp_ready_low_ok", {31'd0, (max_run <= 1)}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
